// File: rtl/subsurf_pkg.sv
// Shared subsurf definitions: RES RAM geometry, per-element word counts and
// the result-streamer state encoding.
package subsurf_pkg;

  localparam int ADDR_WIDTH = 9;
  localparam int VTX_WORDS  = 3;
  localparam int FACE_WORDS = 4;

  typedef enum logic [2:0] {
    RS_IDLE,
    RS_CALC,
    RS_HDR,
    RS_READ,
    RS_DRAIN
  } res_stream_state_t;

  // Unclamped payload length in 32-bit words; 36 bits cannot overflow for 32-bit counts.
  function automatic logic [35:0] payload_words(input logic [31:0] vc,
                                                input logic [31:0] fc,
                                                input int unsigned vw,
                                                input int unsigned fw);
    return 36'(vw) * {4'b0, vc} + 36'(fw) * {4'b0, fc};
  endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO for the output stream; head entry is always a register, so
// the stream outputs driven from it are glitch-free and stable while stalled.
module stream_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/res_streamer.sv
// Streams the subdivided mesh out of the RES RAM: two header words (vertex and
// face counts) followed by the payload, on a 32-bit valid/ready interface.
module res_streamer
  import subsurf_pkg::*;
#(
  parameter int ADDR_WIDTH = subsurf_pkg::ADDR_WIDTH,
  parameter int BASE_ADDR  = 0,
  parameter int VTX_WORDS  = subsurf_pkg::VTX_WORDS,
  parameter int FACE_WORDS = subsurf_pkg::FACE_WORDS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           vertex_count,
  input  logic [31:0]           face_count,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [3:0]            ram_we,
  output logic [31:0]           ram_di,
  input  logic [31:0]           ram_do,
  output logic [31:0]           m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  overflow,
  output res_stream_state_t     fsm_state
);

  // Stream handshake: a word transfers on any rising edge where m_valid && m_ready;
  // once m_valid rises, m_data/m_last stay fixed until that transfer happens.

  localparam int CAP = (1 << ADDR_WIDTH) - BASE_ADDR;

  res_stream_state_t   state_q, state_d;
  logic [31:0]         vc_q, fc_q;
  logic [ADDR_WIDTH:0] n_q;
  logic [ADDR_WIDTH:0] k_q, k_d;
  logic                hdr_sel_q, hdr_sel_d;
  logic                pend_q, pend_last_q;
  logic                overflow_q;
  logic [ADDR_WIDTH-1:0] ram_a_q;
  logic [ADDR_WIDTH-1:0] addr_now;
  logic [35:0]         n_raw;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [32:0]         fifo_din, fifo_dout;
  logic [1:0]          fifo_count;
  logic                room;

  stream_fifo2 #(.W(33)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_valid   = !fifo_empty;
  assign m_data    = fifo_dout[31:0];
  assign m_last    = fifo_dout[32] && m_valid;
  assign fifo_pop  = m_valid && m_ready;
  assign busy      = (state_q != RS_IDLE);
  assign overflow  = overflow_q;
  assign fsm_state = state_q;
  assign ram_we    = 4'b0;
  assign ram_di    = 32'b0;
  assign n_raw     = payload_words(vc_q, fc_q, VTX_WORDS, FACE_WORDS);
  assign addr_now  = ADDR_WIDTH'(BASE_ADDR) + k_q[ADDR_WIDTH-1:0];
  assign ram_a     = ram_en ? addr_now : ram_a_q;

  // Occupancy plus the read landing next cycle must leave a free slot, net of this cycle's pop.
  assign room = ({1'b0, fifo_count} + {2'b0, pend_q}) < (3'd2 + {2'b0, fifo_pop});

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    hdr_sel_d = hdr_sel_q;
    ram_en    = 1'b0;
    fifo_push = 1'b0;
    fifo_din  = '0;
    if (pend_q) begin
      fifo_push = 1'b1;
      fifo_din  = {pend_last_q, ram_do};
    end
    case (state_q)
      RS_IDLE: if (start) state_d = RS_CALC;
      RS_CALC: begin
        state_d   = RS_HDR;
        k_d       = '0;
        hdr_sel_d = 1'b0;
      end
      RS_HDR: begin
        if (!fifo_full || fifo_pop) begin
          fifo_push = 1'b1;
          if (!hdr_sel_q) begin
            fifo_din  = {1'b0, vc_q};
            hdr_sel_d = 1'b1;
          end else begin
            fifo_din = {(n_q == '0), fc_q};
            state_d  = (n_q == '0) ? RS_DRAIN : RS_READ;
          end
        end
      end
      RS_READ: begin
        if (room && (k_q < n_q)) begin
          ram_en = 1'b1;
          k_d    = k_q + 1'b1;
          if (k_q == n_q - 1'b1) state_d = RS_DRAIN;
        end
      end
      RS_DRAIN: if (fifo_pop && m_last) state_d = RS_IDLE;
      default: state_d = RS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RS_IDLE;
      vc_q        <= '0;
      fc_q        <= '0;
      n_q         <= '0;
      k_q         <= '0;
      hdr_sel_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      overflow_q  <= 1'b0;
      ram_a_q     <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      hdr_sel_q   <= hdr_sel_d;
      pend_q      <= ram_en;
      pend_last_q <= ram_en && (k_q == n_q - 1'b1);
      if (ram_en) ram_a_q <= addr_now;
      if (state_q == RS_IDLE && start) begin
        vc_q       <= vertex_count;
        fc_q       <= face_count;
        overflow_q <= 1'b0;
      end
      if (state_q == RS_CALC) begin
        if (n_raw > 36'(CAP)) begin
          n_q        <= (ADDR_WIDTH+1)'(CAP);
          overflow_q <= 1'b1;
        end else begin
          n_q <= n_raw[ADDR_WIDTH:0];
        end
      end
    end
  end

endmodule
